// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  localparam int unsigned DefaultMemWords = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream little-endian into 32-bit words; strobes word_valid_o on every 4th byte.
module word_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shreg_q, shreg_d;

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clear_i) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      // Oldest byte drifts down to [7:0] after three shifts.
      shreg_d = {byte_i, shreg_q[23:8]};
    end
  end

  assign word_valid_o = byte_valid_i & ~clear_i & (cnt_q == 2'd3);
  assign word_o       = {byte_i, shreg_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes it into instruction memory,
// holding the CPU in reset until a clean load completes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DefaultMemWords
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_no,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        byte_ok;
  logic        pk_valid;
  logic        pk_word_valid;
  logic [31:0] pk_word;

  // A start pulse always wins over a coincident byte.
  assign byte_ok  = rx_valid_i & ~start_i;
  assign pk_valid = byte_ok & ((state_q == StLen) | (state_q == StData));

  word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (start_i),
    .byte_valid_i (pk_valid),
    .byte_i       (rx_data_i),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start_i) begin
      state_d = StLen;
      len_d   = '0;
      idx_d   = '0;
      csum_d  = '0;
    end else begin
      unique case (state_q)
        StLen: begin
          if (pk_word_valid) begin
            len_d   = pk_word;
            state_d = ((pk_word == 32'd0) || (pk_word > MEM_WORDS)) ? StErr : StData;
          end
        end
        StData: begin
          if (byte_ok) begin
            csum_d = csum_q ^ rx_data_i;
            if (pk_word_valid) begin
              we_d    = 1'b1;
              addr_d  = idx_q << 2;
              wdata_d = pk_word;
              idx_d   = idx_q + 32'd1;
              if (idx_q + 32'd1 == len_q) state_d = StCsum;
            end
          end
        end
        StCsum: begin
          if (byte_ok) state_d = (rx_data_i == csum_q) ? StDone : StErr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q == StLen) | (state_q == StData) | (state_q == StCsum);
  assign done_o      = (state_q == StDone);
  assign error_o     = (state_q == StErr);
  assign core_rst_no = (state_q == StDone);

endmodule
